pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and stall sequencer for the 4-stage core (IF, ID, EXMEM, WB). It drives the `stall` input of the ID→EXMEM pipeline register and the PC and IF/ID hold/flush controls. It computes the per-operand forward flags that travel down the pipe with each instruction. It also runs the level handshake with the data memory / NIC port, including a timeout watchdog.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 64: maximum number of WAIT cycles before the error state; legal range 1..1023.

Ports (reset: synchronous, active-high, `reset`; clock: `clk`):
- `clk` — in — 1 — clock
- `reset` — in — 1 — synchronous reset, active-high
- `id_rA`, `id_rB` — in — 5 each — source register numbers of the instruction in ID
- `id_rA_used`, `id_rB_used` — in — 1 each — the corresponding source is actually read
- `exmem_rD` — in — 5 — destination of the instruction in EXMEM
- `exmem_wrEn`, `exmem_memEn`, `exmem_memwrEn` — in — 1 each — EXMEM register-write, memory-access and memory-write enables
- `exmem_br_taken` — in — 1 — branch resolved taken in EXMEM
- `dmem_ack` — in — 1 — memory completes the current access this cycle
- `dmem_req` — out — 1 — memory request, level; `dmem_we` qualifies it
- `dmem_we` — out — 1 — copy of `exmem_memwrEn` while `dmem_req` is high, else 0
- `stall_pc`, `stall_ifid`, `stall_idex` — out — 1 each — hold PC / hold IF/ID / hold ID→EXMEM
- `bubble_idex` — out — 1 — force the ID-side `wrEn`/`memEn`/`memwrEn` to 0 at the ID→EXMEM input
- `flush_ifid` — out — 1 — load a NOP into IF/ID
- `fwd_rA`, `fwd_rB` — out — 1 each — forward flags presented with the ID instruction
- `mem_timeout` — out — 1 — sticky error flag

## Operation
- The FSM is registered and has three states: RUN, WAIT, ERR. Reset puts it in RUN.
- Memory stall (mstall) is defined as `exmem_memEn & !dmem_ack` while in RUN or WAIT. In ERR, mstall is constantly 1.
- In RUN with `exmem_memEn=1`:
  - `dmem_req=1`.
  - If `dmem_ack=0`, go to WAIT and clear the counter.
  - If `dmem_ack=1`, stay in RUN (single-cycle access).
- In WAIT:
  - `dmem_req` is held at 1. The request may not drop before ack.
  - The counter increments every cycle.
  - On `dmem_ack`, return to RUN.
  - If the counter reaches `MEM_TIMEOUT` with no ack, go to ERR.
- In ERR:
  - `mem_timeout=1`, `dmem_req=0`, and all stalls are held at 1.
  - Only `reset` exits ERR.
- RAW detection (rhaz): `exmem_wrEn & exmem_rD!=0 & ((id_rA_used & id_rA==exmem_rD) | (id_rB_used & id_rB==exmem_rD))`.
- r0 is hardwired zero and never creates a hazard.
- A WB-stage producer needs no action, because the register file writes before it reads.
- Priority order: ERR, then mstall, then branch flush, then rhaz.
  - **mstall:** `stall_pc=stall_ifid=stall_idex=1`, `bubble_idex=0`, `flush_ifid=0`. A taken branch waits until the stall clears.
  - **`exmem_br_taken` (no mstall):** `flush_ifid=1` and `bubble_idex=1`. The ID instruction is the wrong path and is killed. Stalls are 0.
  - **rhaz (no mstall, no branch):** handling depends on the configuration (see Configuration).
- `fwd_rA` is the rA term of rhaz; `fwd_rB` is the rB term. They are meaningful only when `bubble_idex=0`.

## Timing
- All outputs except `mem_timeout` are combinational from the FSM state and the current inputs, with zero-cycle latency.
- `mem_timeout` is registered and rises on the cycle ERR is entered.
- Reset values: FSM=RUN, counter=0, `mem_timeout=0`.
- A single-cycle memory (ack in the same cycle as the request) adds 0 stall cycles.
- An N-cycle ack adds N-1 stall cycles.
- Reset asserted in WAIT: `dmem_req` drops the next cycle and any in-flight ack is ignored.
- Counter width is `$clog2(MEM_TIMEOUT+1)`. The counter saturates and never wraps.
- ack arriving in the same cycle the counter reaches `MEM_TIMEOUT`: the ack wins and the FSM returns to RUN.

## Configuration
- `HAZARD_FWD_EN` defined: rhaz produces `fwd_rA`/`fwd_rB` with no stall. The EX stage takes the WB result, and a load result arrives via the memory ack path.
- `HAZARD_FWD_EN` undefined:
  - `fwd_rA=fwd_rB=0`.
  - rhaz gives `stall_pc=stall_ifid=1` and `bubble_idex=1` for exactly one cycle; the producer then moves to WB.
  - No counter state is involved.

## Structure
- Shared package `cpu_pkg` holds:
  - the FSM state typedef (RUN/WAIT/ERR);
  - the constant `REG_ZERO=5'd0`;
  - the register-index width `REG_W=5`.
- One sub-module, `hazard_detect`: combinational RAW comparison producing the rhaz / `fwd_rA` / `fwd_rB` terms. The FSM, counter and priority logic stay in the top module.

## Test plan
- **Forwarding:** ID reads r3 (`id_rA=3`, used), EXMEM `wrEn=1`, `rD=3`.
  - With `HAZARD_FWD_EN`: `fwd_rA=1`, `fwd_rB=0`, no stall.
  - Without it: one cycle of `stall_pc=stall_ifid=bubble_idex=1`, then released.
- **r0 filter:** `exmem_rD=0`, `id_rA=0`, both enables set → `fwd_rA=0`, no stall.
- **Memory wait:** `exmem_memEn=1`, ack after 4 cycles → `dmem_req` high for 4 cycles, `stall_idex=1` for 3 cycles, FSM back to RUN on the ack cycle.
- **Branch during wait:** `exmem_br_taken=1` while ack is pending for 2 cycles → no flush during the wait; `flush_ifid=1` and `bubble_idex=1` on the ack cycle.
- **Timeout:** `MEM_TIMEOUT=8`, no ack → `mem_timeout=1` after 8 WAIT cycles, stalls stuck at 1, `dmem_req=0`. Asserting `reset` clears everything to the reset values.
- **Simultaneous hazards:** rhaz on both rA and rB while EXMEM is a store with ack in the same cycle → `fwd_rA=fwd_rB=1`, `dmem_we=1`, no stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared CPU types: FSM states and register-index constants.
// Imported by the hazard controller and its RAW comparator.
package cpu_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Level request/ack handshake to the data memory / NIC port.
// master = hazard controller, slave = memory side.
interface pipeline_hazard_ctrl_if;

  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    output dmem_ack
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_detect.sv
// RAW comparator between the ID sources and the EXMEM destination.
// r0 never matches; WB producers are covered by write-before-read.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0] id_rA,
  input  logic [REG_W-1:0] id_rB,
  input  logic             id_rA_used,
  input  logic             id_rB_used,
  input  logic [REG_W-1:0] exmem_rD,
  input  logic             exmem_wrEn,
  output logic             hit_a,
  output logic             hit_b,
  output logic             rhaz
);

  logic prod;

  assign prod  = exmem_wrEn & (exmem_rD != REG_ZERO);
  assign hit_a = prod & id_rA_used & (id_rA == exmem_rD);
  assign hit_b = prod & id_rB_used & (id_rB == exmem_rD);
  assign rhaz  = hit_a | hit_b;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer with dmem handshake and timeout watchdog.
// HAZARD_FWD_EN: resolve EXMEM RAW by forwarding instead of a bubble.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rA,
  input  logic [REG_W-1:0] id_rB,
  input  logic             id_rA_used,
  input  logic             id_rB_used,
  input  logic [REG_W-1:0] exmem_rD,
  input  logic             exmem_wrEn,
  input  logic             exmem_memEn,
  input  logic             exmem_memwrEn,
  input  logic             exmem_br_taken,
  pipeline_hazard_ctrl_if.master dmem,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             fwd_rA,
  output logic             fwd_rB,
  output logic             mem_timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  mem_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             req, mstall;
  logic             hit_a, hit_b, rhaz;
  logic             in_err, sel_ms, sel_br, sel_hz;

  hazard_detect u_detect (
    .id_rA      (id_rA),
    .id_rB      (id_rB),
    .id_rA_used (id_rA_used),
    .id_rB_used (id_rB_used),
    .exmem_rD   (exmem_rD),
    .exmem_wrEn (exmem_wrEn),
    .hit_a      (hit_a),
    .hit_b      (hit_b),
    .rhaz       (rhaz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state_n == ERR)
        mem_timeout <= 1'b1;
    end
  end

  // saturating: never wraps past the watchdog limit
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req     = 1'b0;
    mstall  = 1'b0;
    unique case (state)
      RUN: begin
        mstall = exmem_memEn & ~dmem.dmem_ack;
        if (exmem_memEn) begin
          req = 1'b1;
          if (!dmem.dmem_ack) begin
            state_n = WAIT;
            cnt_n   = '0;
          end
        end
      end
      WAIT: begin
        req    = 1'b1;
        mstall = exmem_memEn & ~dmem.dmem_ack;
        cnt_n  = cnt_inc;
        if (dmem.dmem_ack)
          state_n = RUN;
        else if (cnt_inc == CNT_MAX)
          state_n = ERR;
      end
      ERR: begin
        mstall = 1'b1;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  assign dmem.dmem_req = req;
  assign dmem.dmem_we  = req & exmem_memwrEn;

  assign in_err = (state == ERR);
  assign sel_ms = mstall & ~in_err;
  assign sel_br = exmem_br_taken & ~mstall;
  assign sel_hz = rhaz & ~mstall & ~exmem_br_taken;

  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    fwd_rA      = 1'b0;
    fwd_rB      = 1'b0;
`ifdef HAZARD_FWD_EN
    if (!in_err) begin
      fwd_rA = hit_a;
      fwd_rB = hit_b;
    end
`endif
    unique case (1'b1)
      in_err, sel_ms: begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        stall_idex = 1'b1;
      end
      sel_br: begin
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end
      sel_hz: begin
`ifndef HAZARD_FWD_EN
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
`endif
      end
      default: begin
      end
    endcase
  end

`ifndef HAZARD_FWD_EN
  logic unused_hits;
  assign unused_hits = hit_a ^ hit_b;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=8).
// Expectations follow HAZARD_FWD_EN when defined.
module tb_pipeline_hazard_ctrl;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rA, id_rB, exmem_rD;
  logic id_rA_used, id_rB_used;
  logic exmem_wrEn, exmem_memEn, exmem_memwrEn, exmem_br_taken;
  logic stall_pc, stall_ifid, stall_idex, bubble_idex, flush_ifid;
  logic fwd_rA, fwd_rB, mem_timeout;
  int tests = 0;
  int fails = 0;

  pipeline_hazard_ctrl_if dif();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rA          (id_rA),
    .id_rB          (id_rB),
    .id_rA_used     (id_rA_used),
    .id_rB_used     (id_rB_used),
    .exmem_rD       (exmem_rD),
    .exmem_wrEn     (exmem_wrEn),
    .exmem_memEn    (exmem_memEn),
    .exmem_memwrEn  (exmem_memwrEn),
    .exmem_br_taken (exmem_br_taken),
    .dmem           (dif),
    .stall_pc       (stall_pc),
    .stall_ifid     (stall_ifid),
    .stall_idex     (stall_idex),
    .bubble_idex    (bubble_idex),
    .flush_ifid     (flush_ifid),
    .fwd_rA         (fwd_rA),
    .fwd_rB         (fwd_rB),
    .mem_timeout    (mem_timeout)
  );

  always #5 clk = ~clk;

  // {spc,sif,sid,bub,flush,fa,fb,req,we,timeout}
  function automatic logic [9:0] v(
    input logic a, b, c, d, e, f, g, h, i, j);
    return {a, b, c, d, e, f, g, h, i, j};
  endfunction

  function automatic logic [9:0] obs();
    return {stall_pc, stall_ifid, stall_idex, bubble_idex,
            flush_ifid, fwd_rA, fwd_rB, dif.dmem_req,
            dif.dmem_we, mem_timeout};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] o;
    #1;
    o = obs();
    tests++;
    assert (o === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rA = 0; id_rB = 0; exmem_rD = 0;
    id_rA_used = 0; id_rB_used = 0;
    exmem_wrEn = 0; exmem_memEn = 0;
    exmem_memwrEn = 0; exmem_br_taken = 0;
    dif.dmem_ack = 0;
  endtask

  logic [9:0] Z, MS, ERRV, HZA, HZB, SIM;

  initial begin
    Z    = '0;
    MS   = v(1,1,1,0,0,0,0,1,0,0);
    ERRV = v(1,1,1,0,0,0,0,0,0,1);
`ifdef HAZARD_FWD_EN
    HZA = v(0,0,0,0,0,1,0,0,0,0);
    HZB = v(0,0,0,0,0,0,1,0,0,0);
    SIM = v(0,0,0,0,0,1,1,1,1,0);
`else
    HZA = v(1,1,0,1,0,0,0,0,0,0);
    HZB = HZA;
    SIM = v(1,1,0,1,0,0,0,1,1,0);
`endif
    clr();
    reset = 1;
    cyc(); cyc();
    chk("reset_hold", Z);
    reset = 0;
    cyc();
    chk("idle", Z);

    // RAW on rA, then producer leaves EXMEM
    id_rA = 3; id_rA_used = 1; exmem_rD = 3; exmem_wrEn = 1;
    chk("raw_rA", HZA);
    cyc();
    exmem_wrEn = 0;
    chk("raw_release", Z);

    cyc(); clr();
    id_rB = 7; id_rB_used = 1; exmem_rD = 7; exmem_wrEn = 1;
    chk("raw_rB", HZB);
    id_rB_used = 0;
    chk("rB_unused", Z);

    cyc(); clr();
    id_rA_used = 1; exmem_wrEn = 1;
    chk("r0_filter", Z);

    // 4-cycle memory access
    cyc(); clr();
    exmem_memEn = 1;
    chk("mw_run", MS);
    cyc(); chk("mw_wait1", MS);
    cyc(); chk("mw_wait2", MS);
    cyc(); dif.dmem_ack = 1;
    chk("mw_ack", v(0,0,0,0,0,0,0,1,0,0));
    cyc(); clr();
    chk("mw_back_run", Z);

    // branch held off by memory stall
    cyc(); clr();
    exmem_memEn = 1; exmem_br_taken = 1;
    chk("br_wait0", MS);
    cyc(); chk("br_wait1", MS);
    cyc(); dif.dmem_ack = 1;
    chk("br_ack", v(0,0,0,1,1,0,0,1,0,0));
    cyc(); clr();
    exmem_br_taken = 1;
    chk("br_plain", v(0,0,0,1,1,0,0,0,0,0));

    // store with both operands hazarding, single-cycle ack
    cyc(); clr();
    id_rA = 5; id_rB = 5; id_rA_used = 1; id_rB_used = 1;
    exmem_rD = 5; exmem_wrEn = 1;
    exmem_memEn = 1; exmem_memwrEn = 1; dif.dmem_ack = 1;
    chk("sim_haz", SIM);
    cyc(); clr();
    chk("sim_after", Z);

    // ack on the cycle the counter reaches the limit
    cyc(); clr();
    exmem_memEn = 1;
    chk("race_run", MS);
    for (int i = 0; i < 7; i++) begin
      cyc(); chk("race_wait", MS);
    end
    cyc(); dif.dmem_ack = 1;
    chk("race_ack", v(0,0,0,0,0,0,0,1,0,0));
    cyc(); clr();
    chk("race_run_again", Z);

    // full timeout
    cyc(); clr();
    exmem_memEn = 1;
    chk("to_run", MS);
    for (int i = 0; i < 8; i++) begin
      cyc(); chk("to_wait", MS);
    end
    cyc();
    chk("to_err", ERRV);
    clr(); dif.dmem_ack = 1;
    cyc();
    chk("to_sticky", ERRV);
    clr();
    reset = 1;
    cyc();
    chk("to_reset", Z);
    reset = 0;
    cyc();
    chk("to_after_reset", Z);

    // reset while waiting, with an ack in flight
    exmem_memEn = 1;
    chk("rw_run", MS);
    cyc(); chk("rw_wait", MS);
    reset = 1; dif.dmem_ack = 1;
    cyc();
    reset = 0; clr();
    chk("rw_dropped", Z);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
